// File: rtl/mips_multicycle_ctrl_pkg.sv
// ============================================================================
// Module  : mips_multicycle_ctrl_pkg
// Brief   : Opcodes, state encodings and datapath select encodings shared by
//           the multicycle MIPS controller, its datapath and its bench.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_multicycle_ctrl_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_ADDI  = 6'h08;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EXEC = 4'd10,
    ST_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OPC_RTYPE) || (op == OPC_LW) || (op == OPC_SW) ||
           (op == OPC_BEQ) || (op == OPC_J) || (op == OPC_ADDI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_ctrl_decode.sv
// ============================================================================
// Module  : mips_ctrl_decode
// Brief   : Combinational state-to-control-vector decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_ctrl_decode
  import mips_multicycle_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.illegal_op = !is_legal_op(opcode);
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      ST_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      ST_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
// Module  : mips_multicycle_ctrl
// Brief   : Multicycle MIPS control FSM: state register and next-state logic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       instr_done
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  ctrl_t  w_gated;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH:     if (mem_ready) w_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OPC_LW, OPC_SW: w_next = ST_MEM_ADDR;
          OPC_RTYPE:      w_next = ST_R_EXEC;
          OPC_BEQ:        w_next = ST_BRANCH;
          OPC_J:          w_next = ST_JUMP;
          OPC_ADDI:       w_next = ST_ADDI_EXEC;
          default:        w_next = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR:  w_next = (opcode == OPC_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  if (mem_ready) w_next = ST_MEM_WB;
      ST_MEM_WRITE: if (mem_ready) w_next = ST_FETCH;
      ST_R_EXEC:    w_next = ST_R_WB;
      ST_ADDI_EXEC: w_next = ST_ADDI_WB;
      default:      w_next = ST_FETCH;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state     (r_state),
    .mem_ready (mem_ready),
    .opcode    (opcode),
    .ctrl      (w_ctrl)
  );

  // Outputs are gated by rst_n so writes drop the instant reset asserts.
  assign w_gated = rst_n ? w_ctrl : '0;

  assign reg_dst       = w_gated.reg_dst;
  assign reg_write     = w_gated.reg_write;
  assign mem_to_reg    = w_gated.mem_to_reg;
  assign mem_read      = w_gated.mem_read;
  assign mem_write     = w_gated.mem_write;
  assign i_or_d        = w_gated.i_or_d;
  assign ir_write      = w_gated.ir_write;
  assign pc_write      = w_gated.pc_write;
  assign pc_write_cond = w_gated.pc_write_cond;
  assign pc_source     = w_gated.pc_source;
  assign alu_src_a     = w_gated.alu_src_a;
  assign alu_src_b     = w_gated.alu_src_b;
  assign alu_op        = w_gated.alu_op;
  assign illegal_op    = w_gated.illegal_op;
  assign instr_done    = w_gated.instr_done;
  assign state         = rst_n ? r_state : 4'd0;

endmodule

`default_nettype wire
